// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic logic [NUM_CH-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
    return NUM_CH'(1) << slot;
  endfunction

endpackage

// File: rtl/demux_1to4_tdm_slot_ctr.sv
// 2-bit TDM slot counter: increments on enable, load-to-1 on realign, clears on reset.
module tdm_slot_ctr
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  output logic [SLOT_W-1:0] cnt
);

  logic [SLOT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load1) begin
      cnt_q <= SLOT_W'(1);
    end else if (en) begin
      cnt_q <= cnt_q + SLOT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/demux_1to4_tdm.sv
// 1:4 TDM demultiplexer with HUNT/LOCK frame alignment and sync realignment.
// Define DEMUX_FRAME_LATCH_EN to stage slots 0-2 and publish whole frames on slot 3.
module demux_1to4_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  state_e             state_q;
  logic [WIDTH-1:0]   y_q [NUM_CH];
  logic [NUM_CH-1:0]  y_valid_q;
  logic               frame_done_q;
  logic               sync_err_q;

  logic [SLOT_W-1:0]  cnt;
  logic               wr_en;
  logic [SLOT_W-1:0]  wr_slot;
  logic               cnt_load1;
  logic               cnt_inc;
  logic               sync_err_d;
  logic               last_beat;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_inc),
    .load1 (cnt_load1),
    .cnt   (cnt)
  );

  // A sync beat always lands in slot 0; plain beats only count once locked.
  always_comb begin
    wr_en      = 1'b0;
    wr_slot    = cnt;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    sync_err_d = 1'b0;
    if (d_valid) begin
      if (sync) begin
        wr_en      = 1'b1;
        wr_slot    = '0;
        cnt_load1  = 1'b1;
        sync_err_d = (state_q == LOCK) && (cnt != '0);
      end else if (state_q == LOCK) begin
        wr_en   = 1'b1;
        cnt_inc = 1'b1;
      end
    end
  end

  assign last_beat = wr_en && (wr_slot == SLOT_W'(NUM_CH - 1));

`ifdef DEMUX_FRAME_LATCH_EN
  logic [WIDTH-1:0] stage_q [NUM_CH-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      y_valid_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        y_q[k] <= '0;
      end
`ifdef DEMUX_FRAME_LATCH_EN
      for (int k = 0; k < NUM_CH - 1; k++) begin
        stage_q[k] <= '0;
      end
`endif
    end else begin
      y_valid_q    <= '0;
      frame_done_q <= last_beat;
      sync_err_q   <= sync_err_d;
      if (state_q == HUNT && d_valid && sync) begin
        state_q <= LOCK;
      end
`ifdef DEMUX_FRAME_LATCH_EN
      if (last_beat) begin
        for (int k = 0; k < NUM_CH - 1; k++) begin
          y_q[k] <= stage_q[k];
        end
        y_q[NUM_CH-1] <= d;
        y_valid_q     <= '1;
      end else if (wr_en) begin
        // A realign wipes the later staged slots so the old frame cannot leak out.
        for (int k = 0; k < NUM_CH - 1; k++) begin
          if (wr_slot == SLOT_W'(k)) begin
            stage_q[k] <= d;
          end else if (cnt_load1) begin
            stage_q[k] <= '0;
          end
        end
      end
`else
      if (wr_en) begin
        y_q[wr_slot] <= d;
        y_valid_q    <= slot_onehot(wr_slot);
      end
`endif
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign y_valid    = y_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Scoreboard bench for demux_1to4_tdm; expectations for both DEMUX_FRAME_LATCH_EN builds.
module tb_demux_1to4_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = '0;
  logic       d_valid = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic       frame_done, sync_err, locked;

  int cyc = 0;
  int total = 0;
  int pass_cnt = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  yv;
    logic        fd;
    logic        se;
    logic        lk;
    logic [31:0] y;
  } exp_t;

  exp_t q[$];

  demux_1to4_tdm #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .d_valid    (d_valid),
    .sync       (sync),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .y_valid    (y_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the expectation tagged for this cycle, flags any unscheduled strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        $display("cyc=%0d yv=%b fd=%b se=%b lk=%b y=%h", cyc, y_valid, frame_done,
                 sync_err, locked, {y3, y2, y1, y0});
        chk("y_valid", 32'(y_valid), 32'(e.yv));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("sync_err", 32'(sync_err), 32'(e.se));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("y_data", {y3, y2, y1, y0}, e.y);
      end else if (y_valid != 4'b0 || frame_done || sync_err) begin
        chk("unexpected_strobe", {29'b0, y_valid != 4'b0, frame_done, sync_err}, 32'b0);
      end
    end
  end

  // Called at a negedge: drive one beat and schedule its expected outcome.
  task automatic beat(input logic [7:0] dv, input logic s,
                      input logic [3:0] yv_nm, input logic [31:0] y_nm,
                      input logic [3:0] yv_m, input logic [31:0] y_m,
                      input logic fd, input logic se, input logic lk);
    exp_t e;
    e.cyc = cyc + 1;
`ifdef DEMUX_FRAME_LATCH_EN
    e.yv = yv_m;
    e.y  = y_m;
`else
    e.yv = yv_nm;
    e.y  = y_nm;
`endif
    e.fd = fd;
    e.se = se;
    e.lk = lk;
    q.push_back(e);
    d = dv;
    sync = s;
    d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle(input int n, input logic s);
    d_valid = 1'b0;
    sync = s;
    repeat (n) @(negedge clk);
    sync = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_y", {y3, y2, y1, y0}, 32'h0);
    chk("rst_y_valid", 32'(y_valid), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);

    // HUNT drops non-sync beats
    beat(8'hAA, 0, 4'b0000, 32'h0, 4'b0000, 32'h0, 0, 0, 0);
    beat(8'hBB, 0, 4'b0000, 32'h0, 4'b0000, 32'h0, 0, 0, 0);

    // First frame, sync on slot 0 only
    beat(8'h11, 1, 4'b0001, 32'h00000011, 4'b0000, 32'h0, 0, 0, 1);
    beat(8'h22, 0, 4'b0010, 32'h00002211, 4'b0000, 32'h0, 0, 0, 1);
    beat(8'h33, 0, 4'b0100, 32'h00332211, 4'b0000, 32'h0, 0, 0, 1);
    beat(8'h44, 0, 4'b1000, 32'h44332211, 4'b1111, 32'h44332211, 1, 0, 1);

    // Back-to-back free-running frame without sync
    beat(8'h01, 0, 4'b0001, 32'h44332201, 4'b0000, 32'h44332211, 0, 0, 1);
    beat(8'h02, 0, 4'b0010, 32'h44330201, 4'b0000, 32'h44332211, 0, 0, 1);
    beat(8'h03, 0, 4'b0100, 32'h44030201, 4'b0000, 32'h44332211, 0, 0, 1);
    beat(8'h04, 0, 4'b1000, 32'h04030201, 4'b1111, 32'h04030201, 1, 0, 1);

    // Gap with sync but no d_valid is ignored; sync at cnt=2 realigns
    beat(8'h66, 0, 4'b0001, 32'h04030266, 4'b0000, 32'h04030201, 0, 0, 1);
    idle(1, 1'b1);
    beat(8'h77, 0, 4'b0010, 32'h04037766, 4'b0000, 32'h04030201, 0, 0, 1);
    beat(8'h55, 1, 4'b0001, 32'h04037755, 4'b0000, 32'h04030201, 0, 1, 1);
    beat(8'h88, 0, 4'b0010, 32'h04038855, 4'b0000, 32'h04030201, 0, 0, 1);
    beat(8'h99, 0, 4'b0100, 32'h04998855, 4'b0000, 32'h04030201, 0, 0, 1);
    beat(8'hAB, 0, 4'b1000, 32'hAB998855, 4'b1111, 32'hAB998855, 1, 0, 1);

    // Mid-frame reset after slot 1
    beat(8'hC1, 1, 4'b0001, 32'hAB9988C1, 4'b0000, 32'hAB998855, 0, 0, 1);
    beat(8'hC2, 0, 4'b0010, 32'hAB99C2C1, 4'b0000, 32'hAB998855, 0, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_y", {y3, y2, y1, y0}, 32'h0);
    chk("midrst_y_valid", 32'(y_valid), 32'h0);
    chk("midrst_locked", 32'(locked), 32'h0);
    chk("midrst_flags", {30'b0, frame_done, sync_err}, 32'h0);
    beat(8'hD1, 0, 4'b0000, 32'h0, 4'b0000, 32'h0, 0, 0, 0);
    beat(8'hD2, 1, 4'b0001, 32'h000000D2, 4'b0000, 32'h0, 0, 0, 1);

    idle(3, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/demux_1to4_tdm.md
# demux_1to4_tdm

Receive-side counterpart of the team's 4:1 channel mux: takes a time-division-multiplexed sample stream (one sample per valid beat, slot 0 flagged by a sync strobe) and distributes each sample to one of four registered output channels. Tracks frame alignment with a two-state FSM and a slot counter, flags sync misalignment, and realigns. Sits at the far end of a serialized 4-channel link.

## Interface
- WIDTH, 8, sample width in bits (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- d  input  WIDTH  incoming TDM sample
- d_valid  input  1  d carries a sample this cycle
- sync  input  1  qualifies d as slot 0; ignored when d_valid=0
- y0, y1, y2, y3  output  WIDTH each  registered channel outputs, hold last value
- y_valid  output  4  one-cycle strobe per channel, bit k means yk updated
- frame_done  output  1  one-cycle pulse after slot 3 accepted
- sync_err  output  1  one-cycle pulse when sync arrives with slot counter ≠ 0
- locked  output  1  high in LOCK state

## Operation
- FSM states: HUNT (reset state), LOCK.
- HUNT: beats with d_valid=1, sync=0 are dropped, no output activity. d_valid=1 and sync=1: sample goes to slot 0, cnt←1, go LOCK.
- LOCK: each d_valid beat writes slot cnt, cnt←cnt+1 (2-bit, wraps 3→0).
- LOCK, d_valid=1, sync=1, cnt=0: normal; write slot 0.
- LOCK, d_valid=1, sync=1, cnt≠0: sync_err pulse; sample written to slot 0 (realign), cnt←1; stay LOCK; partial frame not reported via frame_done.
- LOCK, d_valid=1, sync=0, cnt=0: accepted as slot 0 (free-running; sync not required every frame).
- d_valid=0: no state change, no strobes; sync ignored.
- Slot-3 beat: frame_done pulse.
- Reset, any time including mid-frame: state HUNT, cnt 0, y0..y3 = 0, y_valid = 0, frame_done = 0, sync_err = 0, locked = 0; staging registers (if present) cleared; partial frame discarded.

## Timing
- All outputs registered; latency 1 cycle from accepting beat to yk/y_valid/frame_done/sync_err.
- locked rises the cycle after the first sync beat in HUNT.
- Back-to-back d_valid beats supported at full rate; no backpressure.
- sync_err and the realigned slot-0 y_valid[0] strobe are asserted in the same cycle.

## Configuration
- DEMUX_FRAME_LATCH_EN defined: slots 0–2 captured into internal staging registers; on slot-3 beat all four outputs update together, y_valid = 4'b1111 for one cycle alongside frame_done. Realignment on sync_err discards staged slots (stale values never reach outputs).
- Not defined: each yk updates on its own beat with only y_valid[k] set; no staging registers.

## Structure
- Package demux_pkg: NUM_CH = 4, SLOT_W = 2, state enum {HUNT, LOCK}.
- One sub-module: tdm_slot_ctr (2-bit slot counter with enable, load-to-1, synchronous active-low clear); FSM, output registers and staging stay in the top.

## Test plan
- Reset then beats d=8'h11,22,33,44 with sync only on 8'h11 -> y0..y3 = 11,22,33,44; y_valid = 0001,0010,0100,1000 on successive cycles (without macro) or 1111 once (with macro); frame_done once; locked=1.
- Beats before any sync (8'hAA, 8'hBB) in HUNT -> no y_valid, outputs stay 0, locked=0.
- LOCK, cnt=2, beat 8'h55 with sync=1 -> sync_err pulse, y0=55, next beat lands in y1, no frame_done for broken frame.
- Two frames back-to-back, sync only on first -> second frame 8'h01..04 lands in y0..y3, two frame_done pulses 4 cycles apart.
- d_valid gaps: sync=1 with d_valid=0 mid-frame -> ignored, no sync_err, counter unchanged.
- rst_n low for 1 cycle after slot 1 -> all outputs 0, locked=0; next non-sync beats dropped until sync.
